// File: rtl/uart_rx_fifo.sv
// UART receive channel: two-flop input synchroniser, mid-bit sampling
// receiver with optional parity, DEPTH-entry byte FIFO, sticky error
// flags and a level/error interrupt, all behind a simple register bus.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int BAUD_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we,
    input  logic        ren,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx_i,
    output logic        intr_rx
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [7:0] A_BAUD   = 8'h00;
    localparam logic [7:0] A_DATA   = 8'h08;
    localparam logic [7:0] A_CTRL   = 8'h0C;
    localparam logic [7:0] A_STATUS = 8'h14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // Configuration and status registers
    logic [BAUD_W-1:0] baud_q;
    logic              rx_en_q, par_en_q, par_odd_q;
    logic [3:0]        wm_q;
    logic              ovr_q, fe_q, pe_q;
    logic [31:0]       rdata_q;
    logic              intr_q;

    // Receiver state
    logic [1:0]        sync_q;
    state_t            state_q, state_d;
    logic [BAUD_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_bad_q, par_bad_d;
    logic              push, set_fe, set_pe;

    // FIFO
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, rptr_q;
    logic [AW:0]       level;
    logic [7:0]        level8;
    logic              empty, full, pop, push_ok, fifo_clr, ovr_set;

    // Bus decode
    logic wr_baud, wr_ctrl, wr_status, rd_data;
    logic rxs, tick;
    logic [31:0] rd_mux;

    assign rxs       = sync_q[1];
    assign tick      = (cnt_q <= BAUD_W'(1));
    assign wr_baud   = we && (addr == A_BAUD);
    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_status = we && (addr == A_STATUS);
    assign rd_data   = ren && (addr == A_DATA);

    assign level    = wptr_q - rptr_q;
    assign level8   = 8'(level);
    assign empty    = (level == '0);
    assign full     = (level == (AW + 1)'(DEPTH));
    assign pop      = rd_data && !empty;
    assign fifo_clr = wr_ctrl && wdata[3];
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign push_ok  = push && (!full || pop) && !fifo_clr;
    assign ovr_set  = push && full && !pop && !fifo_clr;

    // Two-flop synchroniser on the serial line, idling high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], rx_i};
    end

    // Receiver state, bit timer and data shift register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end
    end

    // Next-state logic: the timer counts down and each frame bit is sampled when it expires
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '0) ? cnt_q : cnt_q - BAUD_W'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        push      = 1'b0;
        set_fe    = 1'b0;
        set_pe    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_en_q && (baud_q >= BAUD_W'(4)) && !rxs) begin
                    cnt_d   = baud_q >> 1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rxs) begin
                        cnt_d     = baud_q;
                        bit_d     = '0;
                        par_bad_d = 1'b0;
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rxs, shift_q[DATA_W-1:1]};
                    cnt_d   = baud_q;
                    if (bit_q == BW'(DATA_W - 1)) state_d = par_en_q ? S_PARITY : S_STOP;
                    else                          bit_d   = bit_q + BW'(1);
                end
            end
            S_PARITY: begin
                if (tick) begin
                    par_bad_d = ((^shift_q) ^ rxs) != par_odd_q;
                    cnt_d     = baud_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rxs) begin
                        if (par_bad_q) set_pe = 1'b1;
                        else           push   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        set_fe  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Disabling the receiver abandons any partial frame
        if (!rx_en_q) begin
            state_d = S_IDLE;
            push    = 1'b0;
            set_fe  = 1'b0;
            set_pe  = 1'b0;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= shift_q;
    end

    // FIFO pointers; a clear overrides any push or pop in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (fifo_clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + (AW + 1)'(1);
            if (pop)     rptr_q <= rptr_q + (AW + 1)'(1);
        end
    end

    // Configuration registers and sticky error flags (set wins over a same-cycle clear)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            baud_q    <= '0;
            rx_en_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            wm_q      <= '0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            if (wr_baud) baud_q <= wdata[BAUD_W-1:0];
            if (wr_ctrl) begin
                rx_en_q   <= wdata[0];
                par_en_q  <= wdata[1];
                par_odd_q <= wdata[2];
                wm_q      <= wdata[7:4];
            end
            ovr_q <= ovr_set | (ovr_q & ~(wr_status & wdata[2]));
            fe_q  <= set_fe  | (fe_q  & ~(wr_status & wdata[3]));
            pe_q  <= set_pe  | (pe_q  & ~(wr_status & wdata[4]));
        end
    end

    // Read multiplexer; a DATA read on an empty FIFO returns zero
    always_comb begin
        rd_mux = '0;
        case (addr)
            A_BAUD:   rd_mux = 32'(baud_q);
            A_CTRL:   rd_mux = {24'b0, wm_q, 1'b0, par_odd_q, par_en_q, rx_en_q};
            A_DATA:   if (!empty) rd_mux = 32'(mem_q[rptr_q[AW-1:0]]);
            A_STATUS: rd_mux = {16'b0, level8, 3'b0, pe_q, fe_q, ovr_q, full, empty};
            default:  rd_mux = '0;
        endcase
    end

    // Registered read data held until the next read, and the registered interrupt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            intr_q  <= 1'b0;
        end else begin
            if (ren) rdata_q <= rd_mux;
            intr_q <= ((wm_q != 4'd0) && (level8 >= {4'b0, wm_q})) || ovr_q || fe_q || pe_q;
        end
    end

    assign rdata   = rdata_q;
    assign intr_rx = intr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are driven on rx_i, a
// queue-based model of the receive channel predicts register reads,
// and a monitor compares every read response against the prediction.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int BAUD_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic        ren = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rx = 1'b1;
    logic        intr;

    uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BAUD_W(BAUD_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .we(we), .ren(ren), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rx_i(rx), .intr_rx(intr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    // Reference model of the channel
    int unsigned bit_n = 0;
    bit          m_rx_en = 0, m_par_en = 0, m_par_odd = 0;
    int          m_wm = 0;
    logic [7:0]  m_q[$];
    bit          m_ovr = 0, m_fe = 0, m_pe = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [7:0] lvl;
        lvl = 8'(m_q.size());
        return {16'h0, lvl, 3'b0, m_pe, m_fe, m_ovr, (m_q.size() == DEPTH), (m_q.size() == 0)};
    endfunction

    function automatic logic [31:0] exp_intr();
        return 32'((m_wm != 0 && m_q.size() >= m_wm) || m_ovr || m_fe || m_pe);
    endfunction

    function automatic bit good_pbit(input logic [7:0] d);
        return bit'($countones(d) % 2) ^ m_par_odd;
    endfunction

    // Bus tasks: entered and left on a falling edge
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
        ren = 1'b1; addr = a;
        @(negedge clk);
        ren = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_ctrl(input bit clr);
        logic [3:0] wm4;
        wm4 = 4'(m_wm);
        bus_write(8'h0C, {24'b0, wm4, clr, m_par_odd, m_par_en, m_rx_en});
    endtask

    task automatic read_data(input string name);
        logic [31:0] e;
        e = '0;
        if (m_q.size() > 0) e = 32'(m_q.pop_front());
        bus_read(8'h08, name, e);
    endtask

    task automatic read_status(input string name);
        bus_read(8'h14, name, exp_status());
    endtask

    task automatic clear_flags(input logic [31:0] bits);
        bus_write(8'h14, bits);
        if (bits[2]) m_ovr = 0;
        if (bits[3]) m_fe  = 0;
        if (bits[4]) m_pe  = 0;
    endtask

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (bit_n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stop, input int hold_low);
        hold_bit(1'b0);
        for (int k = 0; k < DATA_W; k++) hold_bit(d[k]);
        if (m_par_en) hold_bit(pbit);
        hold_bit(stop);
        if (!stop) begin
            rx = 1'b0;
            repeat (hold_low) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Apply the channel's receive rules to one completed frame
    function automatic void model_frame(input logic [7:0] d, input bit pbit, input bit stop);
        if (!stop)
            m_fe = 1;
        else if (m_par_en && ((($countones(d) + int'(pbit)) % 2 == 1) != m_par_odd))
            m_pe = 1;
        else if (m_q.size() == DEPTH)
            m_ovr = 1;
        else
            m_q.push_back(d);
    endfunction

    task automatic rx_frame(input logic [7:0] d, input bit pbit, input bit stop, input int hold_low);
        send_frame(d, pbit, stop, hold_low);
        model_frame(d, pbit, stop);
    endtask

    // Monitor: every read strobe yields a response on the next cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (ren) begin
                @(negedge clk);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_read: got 0x%08h with no prediction queued", rdata);
                end else begin
                    e = sb.pop_front();
                    check(e.name, rdata, e.exp);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         pb, st;
        int         kind, hold;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("reset_rdata", rdata, 32'h0);
        check("reset_intr", 32'(intr), 32'h0);
        read_status("reset_status");
        bus_read(8'h00, "reset_baud", 32'h0);
        bus_read(8'h0C, "reset_ctrl", 32'h0);
        bus_write(8'h04, 32'hFFFF_FFFF);
        bus_read(8'h04, "unmapped", 32'h0);

        // Single 8N1 byte
        bit_n = 87;
        bus_write(8'h00, 32'(bit_n));
        m_rx_en = 1;
        write_ctrl(0);
        bus_read(8'h00, "baud_rb", 32'd87);
        rx_frame(8'hA5, 1'b0, 1'b1, 0);
        read_status("byte_status");
        read_data("byte_data");
        read_status("byte_empty");
        read_data("empty_read");

        // Quarter-bit glitch is a false start
        rx = 1'b0;
        repeat (bit_n / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * bit_n) @(negedge clk);
        read_status("glitch_status");

        // Wrong even-parity bit
        m_par_en = 1; m_par_odd = 0;
        write_ctrl(0);
        rx_frame(8'h3C, ~good_pbit(8'h3C), 1'b1, 0);
        read_status("parity_status");
        check("parity_intr", 32'(intr), exp_intr());
        clear_flags(32'h10);
        repeat (2) @(negedge clk);
        check("parity_intr_clr", 32'(intr), exp_intr());
        rx_frame(8'h3C, good_pbit(8'h3C), 1'b1, 0);
        read_data("parity_ok_data");

        // Stop bit low, line held low afterwards
        m_par_en = 0;
        write_ctrl(0);
        rx_frame(8'h5A, 1'b0, 1'b0, 3 * bit_n);
        read_status("frame_status");
        check("frame_intr", 32'(intr), exp_intr());
        rx_frame(8'hC3, 1'b0, 1'b1, 0);
        read_status("after_frame_status");
        read_data("after_frame_data");
        clear_flags(32'h08);
        repeat (2) @(negedge clk);
        check("frame_intr_clr", 32'(intr), exp_intr());

        // Overrun: 17 bytes into 16 entries
        for (int i = 0; i <= DEPTH; i++) rx_frame(8'(i), 1'b0, 1'b1, 0);
        read_status("overrun_status");
        check("overrun_intr", 32'(intr), exp_intr());
        for (int i = 0; i < DEPTH; i++) read_data("overrun_data");
        read_status("overrun_drained");
        clear_flags(32'h04);

        // Watermark, then receiver disabled mid-frame
        m_wm = 4;
        write_ctrl(0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("wm_intr_below", 32'(intr), exp_intr());
            rx_frame(8'($urandom), 1'b0, 1'b1, 0);
        end
        check("wm_intr_at", 32'(intr), exp_intr());
        fork
            send_frame(8'h99, 1'b0, 1'b1, 0);
            begin
                repeat (4 * bit_n) @(negedge clk);
                m_rx_en = 0;
                write_ctrl(0);
            end
        join
        m_rx_en = 1;
        write_ctrl(0);
        read_status("wm_retained");
        write_ctrl(1);
        m_q.delete();
        bus_read(8'h0C, "ctrl_rb", {24'b0, 4'd4, 4'b0001});
        read_status("clr_status");
        check("clr_intr", 32'(intr), exp_intr());

        // Randomised frames, configurations and reads
        bit_n = $urandom_range(8, 24);
        bus_write(8'h00, 32'(bit_n));
        for (int it = 0; it < 30; it++) begin
            m_par_en  = bit'($urandom_range(0, 1));
            m_par_odd = bit'($urandom_range(0, 1));
            m_wm      = $urandom_range(0, 6);
            write_ctrl(0);
            d    = 8'($urandom);
            kind = $urandom_range(0, 9);
            pb   = good_pbit(d);
            st   = 1'b1;
            hold = 0;
            if (kind == 0) pb = ~pb;
            if (kind == 1) begin st = 1'b0; hold = bit_n; end
            rx_frame(d, pb, st, hold);
            check("rnd_intr", 32'(intr), exp_intr());
            case ($urandom_range(0, 3))
                0: read_data("rnd_data");
                1: read_status("rnd_status");
                2: begin clear_flags(32'h1C); read_status("rnd_clr_status"); end
                default: ;
            endcase
        end
        while (m_q.size() > 0) read_data("drain_data");
        read_status("final_status");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receive channel for the UART peripheral, the next generation of the fixed 8-bit, single-byte receive path in `uart_core`. It adds a synchronised, mid-bit-sampled receiver with configurable data width and optional parity. Received bytes go into a DEPTH-entry FIFO, with sticky error flags and a level-watermark interrupt. It sits on the same `we`/`ren`/`addr` register bus as the existing core.

## Interface
- DATA_W, 8: data bits per frame. Legal range 5..8.
- DEPTH, 16: FIFO entries. Must be a power of 2, at least 2.
- BAUD_W, 16: width of the clocks-per-bit register.
- clk_i  in  1  system clock. This is the only clock.
- rst_ni  in  1  reset, asynchronous and active-low.
- we  in  1  register write strobe, one cycle.
- ren  in  1  register read strobe, one cycle.
- addr  in  8  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, registered. Reset value 0.
- rx_i  in  1  serial input. Idle level is high.
- intr_rx  out  1  level interrupt. Reset value 0.

## Operation
- Registers (unmapped addresses read 0 and ignore writes):
  - 0x00 BAUD[BAUD_W-1:0]: clocks per bit N. Reset 0. The receiver is held in IDLE while N<4.
  - 0x0C CTRL: bit0 rx_en, bit1 par_en, bit2 par_odd, bit3 fifo_clr (write-only, self-clearing, reads 0), bits[7:4] watermark WM. Reset 0.
  - 0x08 DATA: a read pops the FIFO and returns the byte zero-extended. A read while empty returns 0 and does not pop.
  - 0x14 STATUS: bit0 empty, bit1 full, bit2 overrun, bit3 frame_err, bit4 parity_err, bits[15:8] level.
    - Reset: empty=1, all other bits 0.
    - Bits 2-4 are sticky. Writing 1 to a bit clears it.
- Synchroniser: 2 flops on rx_i, reset to 1. The FSM sees only the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: when rx_en=1 and N>=4 and rxs=0, load bit counter with N>>1 and go to START.
  - START: when the counter expires, if rxs=0 reload N and go to DATA. Otherwise it is a false start: go to IDLE.
  - DATA: sample rxs every N cycles, LSB first, for DATA_W bits. Then go to PARITY if par_en, else STOP.
  - PARITY: on the sample, parity_bad = (XOR of data bits ^ sampled bit) != par_odd. Then go to STOP.
  - STOP, sample rxs=1:
    - If parity_bad, set parity_err and discard the byte.
    - Otherwise push the byte into the FIFO.
    - Go to IDLE.
  - STOP, sample rxs=0: set frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE when rxs=1.
- rx_en cleared in any state: go to IDLE on the next cycle and drop the partial frame. The FIFO contents are kept.
- BAUD written mid-frame: the new N is used from the next counter reload.
- FIFO:
  - Read/write pointers are log2(DEPTH)+1 bits and wrap naturally.
  - level = wptr - rptr.
  - Push while full and no pop in the same cycle: set overrun, drop the byte, leave contents unchanged.
  - Push and pop in the same cycle when full: both take effect, level unchanged, no overrun.
  - Push and pop in the same cycle when empty: the read returns 0 and the pushed byte is stored (level becomes 1).
  - fifo_clr: pointers reset to 0 the cycle after the write. It wins over a push in the same cycle.
- intr_rx (registered) = (WM!=0 and level>=WM) or overrun or frame_err or parity_err.

## Timing
- rx_i to rxs: 2 cycles.
- Let t be the first cycle rxs=0 in IDLE.
  - Start validation sample: t+(N>>1).
  - Data bit k sample: t+(N>>1)+(k+1)·N.
  - Parity sample, if enabled: the next N after the last data bit, followed by stop.
- FIFO push: 1 cycle after the stop sample. level and empty update on that same edge.
- rdata: valid the cycle after the ren cycle and held until the next ren. The pop takes effect on the ren edge.
- Register write: takes effect on the edge where we=1.
- intr_rx: asserts 1 cycle after its condition becomes true.
- Async reset: all state returns to reset values immediately. The FSM goes to IDLE and the FIFO empties.

## Test plan
- BAUD=87, rx_en=1; send 0xA5 as 8N1 -> STATUS level=1, empty=0; DATA read returns 0x000000A5; afterwards empty=1.
- 0.25-bit-wide low glitch on idle line -> false start; FIFO stays empty; no error flags set.
- par_en=1, par_odd=0; send 0x3C with a wrong parity bit -> parity_err=1, level=0, intr_rx=1. Writing 0x10 to STATUS clears parity_err and deasserts intr_rx.
- Stop bit driven 0 -> frame_err=1, byte discarded; no new start is recognised until the line returns high.
- DEPTH=16: send 17 bytes 0x00..0x10 -> full=1, overrun=1; 16 reads return 0x00..0x0F in order, then empty.
- WM=4: intr_rx rises 1 cycle after the 4th push. Then clear rx_en mid-frame -> no push; the FIFO retains 4 bytes.
